dbg_hub: RTL and testbench

//  Parametrised debug-bus hub between the host debug port and NUM_SEG memory-like segments.

---
 rtl/dbg_hub.sv | 276 +++++++++++++++++++++++++++
 tb/tb_dbg_hub.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_hub.sv
// dbg_hub: routes host debug accesses to the internal CTL register file (segment 0) or to
// external segments. Reads are tracked in issue order with a per-head timeout. A run/halt/step
// FSM with a PC breakpoint controls the CPU clock enable.
module dbg_hub #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned SEG_ADDR_W = 8,
    parameter int unsigned NUM_SEG    = 4,
    parameter int unsigned PC_W       = 12,
    parameter int unsigned MAX_OUTST  = 4,
    parameter int unsigned TIMEOUT    = 15,
    parameter int unsigned STEP_CYC   = 8,
    localparam int unsigned SEG_W     = $clog2(NUM_SEG)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [SEG_W+SEG_ADDR_W-1:0] dbg_addr,
    input  logic                        dbg_wen,
    input  logic                        dbg_ren,
    input  logic [DATA_W-1:0]           dbg_wdata,
    output logic [DATA_W-1:0]           dbg_rdata,
    output logic                        dbg_rdata_vld,
    output logic                        dbg_busy,
    output logic [SEG_ADDR_W-1:0]       seg_addr,
    output logic [DATA_W-1:0]           seg_wdata,
    output logic [NUM_SEG-1:0]          seg_wen,
    output logic [NUM_SEG-1:0]          seg_ren,
    input  logic [NUM_SEG*DATA_W-1:0]   seg_rdata,
    input  logic [NUM_SEG-1:0]          seg_rdata_vld,
    input  logic [PC_W-1:0]             pc,
    output logic                        cpu_en,
    output logic                        cpu_rst
);

    localparam int unsigned PTR_W = $clog2(MAX_OUTST);
    localparam int unsigned AGE_W = $clog2(TIMEOUT + 1);
    localparam int unsigned CNT_W = $clog2(STEP_CYC + 1);

    localparam logic [SEG_ADDR_W-1:0] AddrSysRst = SEG_ADDR_W'(0);
    localparam logic [SEG_ADDR_W-1:0] AddrRunCtl = SEG_ADDR_W'(1);
    localparam logic [SEG_ADDR_W-1:0] AddrBpLo   = SEG_ADDR_W'(2);
    localparam logic [SEG_ADDR_W-1:0] AddrBpHi   = SEG_ADDR_W'(3);
    localparam logic [SEG_ADDR_W-1:0] AddrStatus = SEG_ADDR_W'(4);
    localparam logic [SEG_ADDR_W-1:0] AddrPcLo   = SEG_ADDR_W'(5);
    localparam logic [SEG_ADDR_W-1:0] AddrPcHi   = SEG_ADDR_W'(6);

    localparam logic [DATA_W-1:0] TimeoutData  = DATA_W'(8'hDE);
    localparam logic [DATA_W-1:0] UnmappedData = DATA_W'(8'hAA);

    typedef enum logic [1:0] {
        StHalt = 2'd0,
        StRun  = 2'd1,
        StStep = 2'd2
    } state_e;

    // Address decode
    logic [SEG_W-1:0]      dec_seg;
    logic [SEG_ADDR_W-1:0] dec_addr;
    logic                  is_ctl;
    logic                  ctl_wr;
    logic                  runctl_wr;
    logic                  status_wr;

    assign dec_seg   = dbg_addr[SEG_ADDR_W +: SEG_W];
    assign dec_addr  = dbg_addr[SEG_ADDR_W-1:0];
    assign is_ctl    = (dec_seg == '0);
    assign ctl_wr    = dbg_wen && is_ctl;
    assign runctl_wr = ctl_wr && (dec_addr == AddrRunCtl);
    assign status_wr = ctl_wr && (dec_addr == AddrStatus);
    assign seg_addr  = dec_addr;
    assign seg_wdata = dbg_wdata;

    // CTL and FSM state
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  step_cnt_q, step_cnt_d;
    logic              arm_q;
    logic              cpu_rst_q;
    logic              bp_en_q;
    logic [PC_W-1:0]   bp_q;
    logic              err_q, err_d;
    logic              bp_hit_q, bp_hit_d;
    logic              bp_hit_set;
    logic              bp_match;

    // Read FIFO
    logic [SEG_W-1:0]     fifo_seg_q  [MAX_OUTST];
    logic [DATA_W-1:0]    fifo_data_q [MAX_OUTST];
    logic [MAX_OUTST-1:0] fifo_have_q;
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]       count_q;
    logic [AGE_W-1:0]     age_q;

    logic                 full;
    logic                 head_valid;
    logic [SEG_W-1:0]     head_seg;
    logic                 head_have;
    logic                 head_ext;
    logic                 head_hit;
    logic                 head_timeout;
    logic                 stray;
    logic                 pop;
    logic                 push;
    logic                 drop;
    logic [NUM_SEG-1:0]   exp_vld;
    logic [DATA_W-1:0]    ctl_rdata;
    logic [DATA_W-1:0]    pop_data;

    logic [DATA_W-1:0]    dbg_rdata_q;
    logic                 dbg_rdata_vld_q;

    assign full       = (count_q == (PTR_W + 1)'(MAX_OUTST));
    assign head_valid = (count_q != '0);
    assign head_seg   = fifo_seg_q[rd_ptr_q];
    assign head_have  = fifo_have_q[rd_ptr_q];
    assign head_ext   = head_valid && !head_have && (head_seg != '0);
    assign head_hit   = head_ext && seg_rdata_vld[head_seg];
    assign head_timeout = head_valid && !head_have && !head_hit &&
                          (age_q == AGE_W'(TIMEOUT - 1));
    assign pop        = head_valid && (head_have || head_hit || head_timeout);
    // A full FIFO still accepts a read in the same cycle its head leaves.
    assign push       = dbg_ren && (!full || pop);
    assign drop       = dbg_ren && !push;
    assign dbg_busy   = full;

    // One-hot strobes to external segments; dropped reads are not forwarded.
    always_comb begin
        seg_wen = '0;
        seg_ren = '0;
        if (!is_ctl) begin
            seg_wen = dbg_wen ? (NUM_SEG'(1) << dec_seg) : '0;
            seg_ren = push ? (NUM_SEG'(1) << dec_seg) : '0;
        end
    end

    // Any valid other than the head's own expected response is a protocol error.
    always_comb begin
        exp_vld = '0;
        if (head_ext) begin
            exp_vld[head_seg] = 1'b1;
        end
        stray = |(seg_rdata_vld & ~exp_vld & ~NUM_SEG'(1));
    end

    // CTL register read mux, sampled into the FIFO entry at issue.
    always_comb begin
        ctl_rdata = UnmappedData;
        case (dec_addr)
            AddrSysRst: ctl_rdata = DATA_W'(cpu_rst_q);
            AddrRunCtl: ctl_rdata = DATA_W'({bp_en_q, 1'b0, state_q == StRun});
            AddrBpLo:   ctl_rdata = DATA_W'(bp_q[7:0]);
            AddrBpHi:   ctl_rdata = DATA_W'(bp_q[PC_W-1:8]);
            AddrStatus: ctl_rdata = DATA_W'({err_q, bp_hit_q, state_q});
            AddrPcLo:   ctl_rdata = DATA_W'(pc[7:0]);
            AddrPcHi:   ctl_rdata = DATA_W'(pc[PC_W-1:8]);
            default:    ;
        endcase
    end

    // Data for the entry leaving the FIFO head.
    always_comb begin
        pop_data = TimeoutData;
        if (head_have) begin
            pop_data = fifo_data_q[rd_ptr_q];
        end else if (head_hit) begin
            pop_data = seg_rdata[head_seg*DATA_W +: DATA_W];
        end
    end

    // FIFO payload storage; only read while the entry is valid, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_seg_q[wr_ptr_q]  <= dec_seg;
            fifo_data_q[wr_ptr_q] <= ctl_rdata;
            fifo_have_q[wr_ptr_q] <= is_ctl;
        end
    end

    // FIFO pointers, head age and registered read return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            age_q           <= '0;
            dbg_rdata_q     <= '0;
            dbg_rdata_vld_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
            age_q   <= (pop || !head_valid) ? '0 : age_q + AGE_W'(1);
            dbg_rdata_vld_q <= pop;
            if (pop) dbg_rdata_q <= pop_data;
        end
    end

    assign dbg_rdata     = dbg_rdata_q;
    assign dbg_rdata_vld = dbg_rdata_vld_q;

    // Breakpoint is masked on the first cycle out of HALT so a restart steps past it.
    assign bp_match = bp_en_q && (pc == bp_q) && !arm_q;

    // Run FSM next state and CPU clock enable.
    always_comb begin
        state_d    = state_q;
        step_cnt_d = step_cnt_q;
        bp_hit_set = 1'b0;
        cpu_en     = 1'b0;
        unique case (state_q)
            StHalt: begin
                if (runctl_wr && dbg_wdata[0]) begin
                    state_d = StRun;
                end else if (runctl_wr && dbg_wdata[1]) begin
                    state_d    = StStep;
                    step_cnt_d = CNT_W'(STEP_CYC - 1);
                end
            end
            StRun: begin
                cpu_en = !bp_match;
                if (bp_match) begin
                    state_d    = StHalt;
                    bp_hit_set = 1'b1;
                end else if (runctl_wr && !dbg_wdata[0]) begin
                    state_d = StHalt;
                end
            end
            StStep: begin
                cpu_en     = 1'b1;
                step_cnt_d = step_cnt_q - CNT_W'(1);
                if (step_cnt_q == '0) state_d = StHalt;
            end
            default: state_d = StHalt;
        endcase
        if (cpu_rst_q) begin
            state_d    = StHalt;
            cpu_en     = 1'b0;
            bp_hit_set = 1'b0;
        end
    end

    // Sticky status flags: set beats a simultaneous write-1-to-clear.
    always_comb begin
        err_d    = err_q;
        bp_hit_d = bp_hit_q;
        if (status_wr && dbg_wdata[3]) err_d    = 1'b0;
        if (status_wr && dbg_wdata[2]) bp_hit_d = 1'b0;
        if (drop || head_timeout || stray) err_d = 1'b1;
        if (bp_hit_set) bp_hit_d = 1'b1;
    end

    // FSM and CTL register state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StHalt;
            step_cnt_q <= '0;
            arm_q      <= 1'b1;
            cpu_rst_q  <= 1'b1;
            bp_en_q    <= 1'b0;
            bp_q       <= '0;
            err_q      <= 1'b0;
            bp_hit_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_cnt_q <= step_cnt_d;
            arm_q      <= (state_q == StHalt);
            err_q      <= err_d;
            bp_hit_q   <= bp_hit_d;
            if (ctl_wr && dec_addr == AddrSysRst) cpu_rst_q <= dbg_wdata[0];
            if (runctl_wr && state_q != StStep)   bp_en_q   <= dbg_wdata[2];
            if (ctl_wr && dec_addr == AddrBpLo)   bp_q[7:0] <= dbg_wdata[7:0];
            if (ctl_wr && dec_addr == AddrBpHi)   bp_q[PC_W-1:8] <= dbg_wdata[PC_W-9:0];
        end
    end

    assign cpu_rst = cpu_rst_q;

endmodule

// File: tb/tb_dbg_hub.sv
// tb_dbg_hub: directed bench for dbg_hub. Read results are checked through an expected-data
// queue filled at issue and drained on each dbg_rdata_vld pulse.
module tb_dbg_hub;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  dbg_addr;
    logic        dbg_wen;
    logic        dbg_ren;
    logic [7:0]  dbg_wdata;
    logic [7:0]  dbg_rdata;
    logic        dbg_rdata_vld;
    logic        dbg_busy;
    logic [7:0]  seg_addr;
    logic [7:0]  seg_wdata;
    logic [3:0]  seg_wen;
    logic [3:0]  seg_ren;
    logic [31:0] seg_rdata;
    logic [3:0]  seg_rdata_vld;
    logic [11:0] pc;
    logic        cpu_en;
    logic        cpu_rst;

    logic        pc_set;
    logic [11:0] pc_set_val;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  sb_q[$];
    logic [7:0]  mon_exp;
    int          n_en;
    logic [11:0] pc0;

    dbg_hub dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .dbg_addr      (dbg_addr),
        .dbg_wen       (dbg_wen),
        .dbg_ren       (dbg_ren),
        .dbg_wdata     (dbg_wdata),
        .dbg_rdata     (dbg_rdata),
        .dbg_rdata_vld (dbg_rdata_vld),
        .dbg_busy      (dbg_busy),
        .seg_addr      (seg_addr),
        .seg_wdata     (seg_wdata),
        .seg_wen       (seg_wen),
        .seg_ren       (seg_ren),
        .seg_rdata     (seg_rdata),
        .seg_rdata_vld (seg_rdata_vld),
        .pc            (pc),
        .cpu_en        (cpu_en),
        .cpu_rst       (cpu_rst)
    );

    always #5 clk = ~clk;

    // CPU model: PC advances on every enabled cycle.
    always @(posedge clk) begin
        if (pc_set) pc <= pc_set_val;
        else if (cpu_en) pc <= pc + 12'd1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every returned read must match the oldest expected value.
    always @(negedge clk) begin
        if (rst_n && dbg_rdata_vld) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_vld", 32'(dbg_rdata_vld), 32'h0);
            end else begin
                mon_exp = sb_q.pop_front();
                check("sb_rdata", 32'(dbg_rdata), 32'(mon_exp));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ctl_wr(input logic [7:0] a, input logic [7:0] d);
        dbg_addr  = {2'd0, a};
        dbg_wdata = d;
        dbg_wen   = 1'b1;
        cyc();
        dbg_wen   = 1'b0;
    endtask

    task automatic rd(input logic [1:0] s, input logic [7:0] a, input logic [7:0] exp);
        dbg_addr = {s, a};
        dbg_ren  = 1'b1;
        sb_q.push_back(exp);
        cyc();
        dbg_ren  = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 200 && sb_q.size() != 0; i++) cyc();
        check(tag, 32'(sb_q.size()), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors",
                 n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        dbg_addr      = '0;
        dbg_wen       = 1'b0;
        dbg_ren       = 1'b0;
        dbg_wdata     = '0;
        seg_rdata     = '0;
        seg_rdata_vld = '0;
        pc_set        = 1'b1;
        pc_set_val    = 12'h123;
        repeat (3) cyc();

        // Reset values
        check("rst_rdata", 32'(dbg_rdata), 32'h0);
        check("rst_vld", 32'(dbg_rdata_vld), 32'h0);
        check("rst_cpu_rst", 32'(cpu_rst), 32'h1);
        check("rst_cpu_en", 32'(cpu_en), 32'h0);
        check("rst_busy", 32'(dbg_busy), 32'h0);
        rst_n  = 1'b1;
        pc_set = 1'b0;
        cyc();
        rd(2'd0, 8'h04, 8'h00);
        rd(2'd0, 8'h01, 8'h00);
        rd(2'd0, 8'h00, 8'h01);
        rd(2'd0, 8'h20, 8'hAA);
        drain("rst_drain");

        // 1: back-to-back CTL / external / CTL reads return in issue order
        dbg_ren  = 1'b1;
        dbg_addr = {2'd0, 8'h05};
        sb_q.push_back(8'h23);
        cyc();
        dbg_addr = {2'd1, 8'h10};
        sb_q.push_back(8'h5A);
        #1;
        check("t1_seg_ren", 32'(seg_ren), 32'h2);
        check("t1_seg_addr", 32'(seg_addr), 32'h10);
        cyc();
        dbg_addr = {2'd0, 8'h06};
        sb_q.push_back(8'h01);
        check("t1_ctl_latency", 32'(dbg_rdata_vld), 32'h1);
        cyc();
        dbg_ren = 1'b0;
        check("t1_pulse_low", 32'(dbg_rdata_vld), 32'h0);
        cyc();
        seg_rdata_vld    = 4'b0010;
        seg_rdata[15:8]  = 8'h5A;
        cyc();
        seg_rdata_vld = '0;
        check("t1_ext_latency", 32'(dbg_rdata_vld), 32'h1);
        drain("t1_drain");

        // Segment write decode
        dbg_addr  = {2'd2, 8'h33};
        dbg_wdata = 8'h77;
        dbg_wen   = 1'b1;
        #1;
        check("wr_seg_wen", 32'(seg_wen), 32'h4);
        check("wr_seg_wdata", 32'(seg_wdata), 32'h77);
        cyc();
        dbg_wen = 1'b0;

        // 2: unanswered reads fill the FIFO, fifth is dropped, head times out
        dbg_ren  = 1'b1;
        dbg_addr = {2'd2, 8'h00};
        for (int i = 0; i < 4; i++) begin
            sb_q.push_back(8'hDE);
            cyc();
        end
        check("t2_busy_full", 32'(dbg_busy), 32'h1);
        cyc();
        dbg_ren = 1'b0;
        for (int i = 5; i < 15; i++) cyc();
        check("t2_no_early_pop", 32'(dbg_rdata_vld), 32'h0);
        cyc();
        check("t2_timeout_vld", 32'(dbg_rdata_vld), 32'h1);
        check("t2_timeout_data", 32'(dbg_rdata), 32'hDE);
        check("t2_busy_clear", 32'(dbg_busy), 32'h0);
        drain("t2_drain");
        rd(2'd0, 8'h04, 8'h08);
        ctl_wr(8'h04, 8'h08);
        rd(2'd0, 8'h04, 8'h00);
        drain("t2_status_drain");

        // 3: breakpoint at 'h010
        ctl_wr(8'h00, 8'h00);
        pc_set     = 1'b1;
        pc_set_val = 12'h000;
        cyc();
        pc_set = 1'b0;
        ctl_wr(8'h02, 8'h10);
        ctl_wr(8'h03, 8'h00);
        ctl_wr(8'h01, 8'h05);
        for (int i = 0; i < 40 && cpu_en; i++) cyc();
        check("t3_bp_cpu_en", 32'(cpu_en), 32'h0);
        check("t3_bp_pc", 32'(pc), 32'h010);
        cyc();
        check("t3_pc_hold", 32'(pc), 32'h010);
        check("t3_halt_cpu_en", 32'(cpu_en), 32'h0);
        rd(2'd0, 8'h04, 8'h04);
        rd(2'd0, 8'h01, 8'h04);
        drain("t3_status_drain");
        ctl_wr(8'h01, 8'h05);
        check("t3_rerun_cpu_en", 32'(cpu_en), 32'h1);
        cyc();
        check("t3_past_bp", 32'(pc), 32'h011);
        ctl_wr(8'h01, 8'h00);
        check("t3_stop_cpu_en", 32'(cpu_en), 32'h0);
        ctl_wr(8'h04, 8'h04);
        rd(2'd0, 8'h04, 8'h00);
        drain("t3_clear_drain");

        // 4: single step gives exactly STEP_CYC enabled cycles
        pc0 = pc;
        ctl_wr(8'h01, 8'h02);
        n_en = 0;
        for (int i = 0; i < 12; i++) begin
            if (cpu_en) n_en++;
            cyc();
        end
        check("t4_step_cycles", 32'(n_en), 32'd8);
        check("t4_step_pc", 32'(pc), 32'(pc0 + 12'd8));
        rd(2'd0, 8'h04, 8'h00);
        drain("t4_drain");

        // 5: SYS_RST while running forces the CPU off and the FSM to HALT
        ctl_wr(8'h01, 8'h01);
        check("t5_run_cpu_en", 32'(cpu_en), 32'h1);
        ctl_wr(8'h00, 8'h01);
        check("t5_rst_cpu_en", 32'(cpu_en), 32'h0);
        check("t5_cpu_rst", 32'(cpu_rst), 32'h1);
        cyc();
        rd(2'd0, 8'h01, 8'h00);
        rd(2'd0, 8'h00, 8'h01);
        drain("t5_drain");

        // 6: async reset with reads outstanding, then a late segment response
        rd(2'd0, 8'h02, 8'h10);
        drain("t6_pre_drain");
        dbg_ren  = 1'b1;
        dbg_addr = {2'd3, 8'h00};
        cyc();
        cyc();
        dbg_ren = 1'b0;
        cyc();
        rst_n = 1'b0;
        #1;
        check("t6_rst_rdata", 32'(dbg_rdata), 32'h0);
        check("t6_rst_vld", 32'(dbg_rdata_vld), 32'h0);
        check("t6_rst_cpu_rst", 32'(cpu_rst), 32'h1);
        check("t6_rst_cpu_en", 32'(cpu_en), 32'h0);
        check("t6_rst_busy", 32'(dbg_busy), 32'h0);
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        seg_rdata_vld = 4'b1000;
        cyc();
        seg_rdata_vld = '0;
        rd(2'd0, 8'h04, 8'h08);
        drain("t6_drain");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
